imem_fetch_queue: RTL and testbench

//   Fetch-side initiator for the combinational instruction memory (imem).

---
 rtl/imem_fetch_queue_if.sv | 42 ++++
 rtl/imem_fetch_queue.sv | 104 ++++++++++
 tb/tb_imem_fetch_queue.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_queue_if.sv
// Fetch-queue bus bundle: imem address/data, the decode valid/ready channel,
// the redirect request and the occupancy readout.
// master = the fetch queue itself, slave = the imem/decode/branch side.
interface imem_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [31:0]   imem_addr;
    logic [31:0]   imem_instr;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [LW-1:0] level;

    modport master (
        output imem_addr,
        input  imem_instr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        input  redirect_valid,
        input  redirect_pc,
        output level
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        output redirect_valid,
        output redirect_pc,
        input  level
    );
endinterface

// File: rtl/imem_fetch_queue.sv
// Fetch-side initiator for a combinational instruction memory.
// Owns the fetch PC, captures {pc, instr} pairs into a small prefetch FIFO
// and presents the FIFO head to decode. A redirect flushes everything and
// reloads the PC; it takes priority over both push and pop.
module imem_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_fetch_queue_if.master   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    // Architectural state
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;

    // FIFO payload storage; only ever read at a valid head, so it needs no reset
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic empty;
    logic full;
    logic pop;
    logic push;

    // Handshake decode: the redirect suppresses the push, and a pop is
    // allowed to free the slot the same-cycle push needs when full.
    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == LW'(DEPTH));
        pop   = !empty && bus.out_ready;
        push  = !bus.redirect_valid && (!full || pop);
    end

    // Next-state computation for PC, pointers and occupancy
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        if (bus.redirect_valid) begin
            // Flush: any pop this cycle is discarded along with the contents
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            wptr_d     = '0;
            rptr_d     = '0;
            level_d    = '0;
        end else begin
            if (push) begin
                wptr_d     = wptr_q + PW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
        end
    end

    // Capture the word imem returns for the current fetch PC
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wptr_q]    <= fetch_pc_q;
            instr_mem_q[wptr_q] <= bus.imem_instr;
        end
    end

    // Head presentation; empty FIFO shows a NOP at pc 0
    always_comb begin
        bus.imem_addr = fetch_pc_q;
        bus.level     = level_q;
        bus.out_valid = !empty;
        bus.out_instr = NOP_INSTR;
        bus.out_pc    = 32'h0;
        if (!empty) begin
            bus.out_instr = instr_mem_q[rptr_q];
            bus.out_pc    = pc_mem_q[rptr_q];
        end
    end
endmodule

// File: tb/tb_imem_fetch_queue.sv
// Directed plus randomized bench for imem_fetch_queue against a queue-based
// reference model of the prefetch FIFO.
module tb_imem_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    imem_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // imem image: the program at low addresses, an address-derived pattern
    // far away so misplaced data is visible after random redirects.
    function automatic logic [31:0] img(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h0060_0113;
            32'h8:   return 32'h0020_81b3;
            default: return (a < 32'h100) ? NOP : ((a ^ 32'hA5A5_0000) | 32'h3);
        endcase
    endfunction

    assign bus.imem_instr = img(bus.imem_addr);

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of {pc, instr} and the next fetch PC
    logic [63:0] mq[$];
    logic [31:0] mpc = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [63:0] h;
        if (mq.size() != 0) begin
            h = mq[0];
            chk("out_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("out_pc",    bus.out_pc,    h[63:32]);
            chk("out_instr", bus.out_instr, h[31:0]);
        end else begin
            chk("out_valid", {31'b0, bus.out_valid}, 32'd0);
            chk("out_pc",    bus.out_pc,    32'h0);
            chk("out_instr", bus.out_instr, NOP);
        end
        chk("imem_addr", bus.imem_addr, mpc);
        chk("level",     32'(bus.level), mq.size());
    endtask

    // One clock cycle: drive inputs at the falling edge, check, advance model
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic pop;
        logic push;
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        check_model();
        pop = (mq.size() != 0) && rdy;
        if (rv) begin
            mq.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            push = (mq.size() < DEPTH) || pop;
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({mpc, img(mpc)});
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;

        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // Reset state
        #1;
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_instr", bus.out_instr, NOP);
        chk("rst_pc",    bus.out_pc, 32'h0);
        chk("rst_addr",  bus.imem_addr, 32'h0);
        chk("rst_level", 32'(bus.level), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Streaming with decode always ready
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

        // Backpressure from a fresh start at pc 0
        step(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);
        chk("bp_level", 32'(bus.level), 32'd4);
        chk("bp_addr",  bus.imem_addr, 32'h10);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'h0);

        // Redirect to an unaligned target with 3 entries queued
        step(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h5);
        chk("rd_level", 32'(bus.level), 32'd0);
        chk("rd_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rd_addr",  bus.imem_addr, 32'h4);
        step(1'b0, 1'b0, 32'h0);
        chk("rd_head_pc",    bus.out_pc, 32'h4);
        chk("rd_head_instr", bus.out_instr, 32'h0060_0113);

        // Redirect colliding with a pop of pc 0
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h8);
        step(1'b1, 1'b0, 32'h0);
        chk("rp_head_pc",    bus.out_pc, 32'h8);
        chk("rp_head_instr", bus.out_instr, 32'h0020_81b3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

        // PC wrap-around
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);

        // Mid-operation reset while full, between clock edges
        step(1'b0, 1'b1, 32'h40);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("mr_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mr_level", 32'(bus.level), 32'd0);
        chk("mr_addr",  bus.imem_addr, 32'h0);
        mq.delete();
        mpc = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 0)
                rpc = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
            else
                rpc = $urandom;
            if ($urandom_range(0, 31) == 0) begin
                for (int j = 0; j < 6; j++) step(1'b0, 1'b0, 32'h0);
            end
            step(rdy, rv, rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
